// File: rtl/mdio_controller.sv
// MDIO management frame engine. MDC runs at clk/2; frames go out MSB first and change on MDC falling edges.
// Read frames release the bus after the 16-bit header and capture 16 bits from MDIO_IN on MDC rising edges.
module mdio_controller #(
    parameter int FRAME_BITS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDIO_START,
    input  logic [31:0] T_DATA,
    input  logic        MDIO_IN,
    output logic        MDC,
    output logic        MDIO_OE,
    output logic        MDIO_OUT,
    output logic [15:0] RD_DATA,
    output logic        DATA_RDY,
    output logic        MDIO_DONE
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT_OUT, READ_IN} state_t;

    localparam logic [4:0] LAST_BIT  = 5'(FRAME_BITS - 1);
    localparam logic [4:0] LAST_READ = 5'd15;

    state_t      state, state_next;
    logic        mdc;
    logic        oe, oe_next;
    logic        out, out_next;
    logic        rdy, rdy_next;
    logic        done, done_next;
    logic        is_read, is_read_next;
    logic [4:0]  cnt, cnt_next;
    logic [31:0] shreg, shreg_next;
    logic [15:0] rd_shift, rd_shift_next;
    logic [15:0] rd_data, rd_data_next;

    // mdc holds the value before the edge: mdc=1 means this edge takes MDC 1->0.
    logic mdc_fall;
    logic mdc_rise;
    assign mdc_fall = mdc;
    assign mdc_rise = ~mdc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mdc      <= 1'b0;
            oe       <= 1'b0;
            out      <= 1'b0;
            rdy      <= 1'b0;
            done     <= 1'b0;
            is_read  <= 1'b0;
            cnt      <= '0;
            shreg    <= '0;
            rd_shift <= '0;
            rd_data  <= '0;
        end else begin
            state    <= state_next;
            mdc      <= ~mdc;
            oe       <= oe_next;
            out      <= out_next;
            rdy      <= rdy_next;
            done     <= done_next;
            is_read  <= is_read_next;
            cnt      <= cnt_next;
            shreg    <= shreg_next;
            rd_shift <= rd_shift_next;
            rd_data  <= rd_data_next;
        end
    end

    always_comb begin
        // NOTE: every next value defaults to its current value (pulses to 0) first, so no latch can be inferred.
        state_next    = state;
        oe_next       = oe;
        out_next      = out;
        rdy_next      = 1'b0;
        done_next     = 1'b0;
        is_read_next  = is_read;
        cnt_next      = cnt;
        shreg_next    = shreg;
        rd_shift_next = rd_shift;
        rd_data_next  = rd_data;

        case (state)
            IDLE: begin
                if (MDIO_START) begin
                    shreg_next   = T_DATA;
                    is_read_next = (T_DATA[29:28] == 2'b10);
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                if (mdc_fall) begin
                    oe_next    = 1'b1;
                    out_next   = shreg[31];
                    shreg_next = {shreg[30:0], 1'b0};
                    cnt_next   = '0;
                    state_next = SHIFT_OUT;
                end
            end
            SHIFT_OUT: begin
                if (mdc_fall) begin
                    if (cnt == LAST_BIT) begin
                        oe_next    = 1'b0;
                        out_next   = 1'b0;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else if (is_read && cnt == LAST_READ) begin
                        // Header sent: hand the bus to the PHY for the data half.
                        oe_next       = 1'b0;
                        out_next      = 1'b0;
                        cnt_next      = '0;
                        rd_shift_next = '0;
                        state_next    = READ_IN;
                    end else begin
                        out_next   = shreg[31];
                        shreg_next = {shreg[30:0], 1'b0};
                        cnt_next   = cnt + 5'd1;
                    end
                end
            end
            READ_IN: begin
                if (mdc_rise) begin
                    rd_shift_next = {rd_shift[14:0], MDIO_IN};
                    if (cnt == LAST_READ) begin
                        rd_data_next = {rd_shift[14:0], MDIO_IN};
                        rdy_next     = 1'b1;
                        done_next    = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        cnt_next = cnt + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign MDC       = mdc;
    assign MDIO_OE   = oe;
    assign MDIO_OUT  = out;
    assign RD_DATA   = rd_data;
    assign DATA_RDY  = rdy;
    assign MDIO_DONE = done;

endmodule

// File: doc/mdio_controller.md
MDIO_CONTROLLER -- requirements
Module: mdio_controller

Interface
REQ-001 The block SHALL have the parameter FRAME_BITS, default 32, meaning the total MDIO frame length in MDC periods.
REQ-002 The block SHALL have the port clk, input, 1 bit: the system clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have the port MDIO_START, input, 1 bit: a transaction request, level-sampled in IDLE.
REQ-005 The block SHALL have the port T_DATA, input, 32 bits [31:0]: the frame to send; [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] write data.
REQ-006 The block SHALL have the port MDIO_IN, input, 1 bit: the serial data driven by the PHY during a read.
REQ-007 The block SHALL have the port MDC, output, 1 bit: the management clock, clk/2.
REQ-008 The block SHALL have the port MDIO_OE, output, 1 bit: high while the controller drives MDIO_OUT.
REQ-009 The block SHALL have the port MDIO_OUT, output, 1 bit: the serial frame bit, MSB first.
REQ-010 The block SHALL have the port RD_DATA, output, 16 bits [15:0]: the data captured in a read.
REQ-011 The block SHALL have the port DATA_RDY, output, 1 bit: a one-clk pulse when RD_DATA is valid.
REQ-012 The block SHALL have the port MDIO_DONE, output, 1 bit: a one-clk pulse at the end of any transaction.

Function
REQ-013 MDC SHALL toggle on every clk rising edge while reset is low, giving a free-running 50% duty cycle clock.
REQ-014 The FSM SHALL have four states: IDLE, LOAD, SHIFT_OUT, READ_IN.
REQ-015 In IDLE, when MDIO_START=1 at a clk edge, the block SHALL latch T_DATA into a 32-bit shift register and go to LOAD; T_DATA changes after that edge SHALL have no effect.
REQ-016 LOAD SHALL wait for the next clk edge on which MDC goes 1->0.
- On that edge, the block SHALL set MDIO_OE=1, drive bit 31 on MDIO_OUT, set the bit counter to 0, and go to SHIFT_OUT.
REQ-017 In SHIFT_OUT, MDIO_OUT SHALL change only on MDC falling edges, presenting bits 31 down to 0 in order, one bit per MDC period.
- The PHY samples on MDC rising edges.
REQ-018 Read frame (OP=2'b10): after 16 driven bits (ST, OP, PHYAD, REGAD, TA), the block SHALL go to READ_IN.
- On the falling edge that would present bit 15, it SHALL set MDIO_OE=0 and MDIO_OUT=0.
REQ-019 In READ_IN, the block SHALL sample MDIO_IN on each clk edge where MDC goes 0->1 and shift it into RD_DATA MSB first, for 16 samples.
REQ-020 After the 16th read sample, the block SHALL pulse DATA_RDY and MDIO_DONE high for exactly one clk and return to IDLE.
- RD_DATA SHALL hold its value until the next read completes or reset.
REQ-021 Write frame (OP other than 2'b10, including 00 and 11): the block SHALL drive all 32 bits.
- On the falling edge after bit 0, it SHALL set MDIO_OE=0 and MDIO_OUT=0, pulse MDIO_DONE for one clk, and go to IDLE.
- DATA_RDY SHALL stay 0.
REQ-022 The block SHALL ignore MDIO_START while not in IDLE; with MDIO_START held high, a new transaction SHALL start in the clk cycle after the return to IDLE.
REQ-023 The bit counter SHALL be 5 bits wide and SHALL NOT wrap during a frame; the terminal count is 31 for writes and 15 for read input.
REQ-024 The block SHALL NOT check ST or TA; they SHALL be transmitted exactly as given in T_DATA.
REQ-025 MDIO_OE SHALL be 0 in IDLE and LOAD.

Reset
REQ-026 While reset=1, the block SHALL force: state=IDLE, MDC=0, MDIO_OE=0, MDIO_OUT=0, RD_DATA=16'h0000, DATA_RDY=0, MDIO_DONE=0, counter=0, shift register=0.
REQ-027 A reset asserted mid-transaction SHALL abort the frame immediately (asynchronous) with no DONE pulse; after release, the block SHALL accept a new MDIO_START.

Verification
REQ-028 Write: T_DATA=32'h5452_5555 with a one-clk MDIO_START -> MDIO_OE=1 for exactly 32 MDC periods; the MDIO_OUT sequence, sampled on MDC rising edges, equals 0101_0100_0101_0010_0101_0101_0101_0101; one MDIO_DONE pulse; DATA_RDY=0.
REQ-029 Read: T_DATA=32'h6A2A_0000, PHY drives 16'hAAAA MSB first, changing on MDC falling edges -> MDIO_OE=1 for 16 periods, then 0; RD_DATA=16'hAAAA; DATA_RDY and MDIO_DONE pulse together for one clk.
REQ-030 Busy: MDIO_START pulsed again at bit 10 of a write -> ignored; exactly one frame and one DONE pulse.
REQ-031 Back-to-back: MDIO_START held high over two frames -> second frame starts after return to IDLE, with no overlap and MDIO_OE low for at least one MDC period between frames.
REQ-032 Reset: reset asserted during READ_IN bit 5 -> all outputs return to REQ-026 values in the same timestep; a following read with PHY data 16'h1234 gives RD_DATA=16'h1234.
REQ-033 OP=2'b11 -> treated as a write: 32 bits driven, DATA_RDY=0.
